// File: rtl/spi_packet_rx.sv
// spi_packet_rx: assembles the spi_rx word stream into checked packets.
// A packet is a header word {SYNC_BYTE, N}, N payload words and a checksum
// word (16-bit wrap-around sum of header and payload). Payload words are
// written speculatively into a FIFO behind a temporary write pointer. They
// become visible on the valid/ready port only once the checksum matches. A
// failed or abandoned packet is discarded by rewinding that pointer.
//
// Build option: define SPI_PKT_STATS_EN to add saturating packet and error
// counters (pkt_count_out, err_count_out). Without it those ports are absent.
module spi_packet_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_PAYLOAD    = 16,
    parameter int         FIFO_DEPTH     = 32,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] data_in,
    input  logic        new_data_in,
    output logic [15:0] word_out,
    output logic        last_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        pkt_ok_out,
    output logic        pkt_err_out,
    output logic [2:0]  err_code_out
`ifdef SPI_PKT_STATS_EN
    ,
    output logic [15:0] pkt_count_out,
    output logic [15:0] err_count_out
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PTR_W+1:0] DEPTH_C   = (PTR_W + 2)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W + 1)'(1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
    localparam logic [8:0]       MAX_N     = 9'(MAX_PAYLOAD);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PAYLOAD = 2'd1;
    localparam logic [1:0] CHECK   = 2'd2;
    localparam logic [1:0] DROP    = 2'd3;

    localparam logic [2:0] ERR_BAD_HDR  = 3'd1;
    localparam logic [2:0] ERR_OVERFLOW = 3'd2;
    localparam logic [2:0] ERR_CHECKSUM = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

    logic [1:0]       state;
    logic [8:0]       cnt;
    logic [15:0]      sum;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   wr_commit;
    logic [PTR_W:0]   wr_tmp;
    logic [TMO_W-1:0] tmo_cnt;
    logic [16:0]      mem [FIFO_DEPTH];

    logic [PTR_W:0]   used;
    logic [PTR_W+1:0] free_cnt;
    logic [15:0]      free_w;
    logic [8:0]       hdr_n;
    logic             hdr_ok;
    logic             hdr_fits;
    logic             pop;
    logic             tmo_hit;
    logic             wr_en;

`ifdef SPI_PKT_STATS_EN
    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    // Header decode, free-space and handshake terms.
    always_comb begin
        used     = wr_commit - rd_ptr;
        free_cnt = DEPTH_C - {1'b0, used};
        free_w   = 16'(free_cnt);
        hdr_n    = {1'b0, data_in[7:0]};
        hdr_ok   = (data_in[15:8] == SYNC_BYTE) && (hdr_n != 9'd0) && (hdr_n <= MAX_N);
        hdr_fits = (free_w >= {7'd0, hdr_n});
        pop      = valid_out && ready_in;
        tmo_hit  = (tmo_cnt == TMO_LIMIT);
        wr_en    = (state == PAYLOAD) && new_data_in;
    end

    // Only committed entries are visible; outputs read as zero when empty.
    assign valid_out = (rd_ptr != wr_commit);
    assign word_out  = valid_out ? mem[rd_ptr[PTR_W-1:0]][15:0] : 16'd0;
    assign last_out  = valid_out & mem[rd_ptr[PTR_W-1:0]][16];

    // Payload storage: speculative writes land at wr_tmp, tagged with the last flag.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_tmp[PTR_W-1:0]] <= {(cnt == 9'd1), data_in};
        end
    end

    // Running checksum: seeded by the header, accumulated over payload words.
    always_ff @(posedge clk_in) begin
        if (new_data_in) begin
            if (state == IDLE) begin
                sum <= data_in;
            end else if (state == PAYLOAD) begin
                sum <= sum + data_in;
            end
        end
    end

    // Read side: the consumer pops independently of the packet FSM.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Packet FSM, write pointers, inter-word timeout and status pulses.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= IDLE;
            cnt          <= '0;
            wr_commit    <= '0;
            wr_tmp       <= '0;
            tmo_cnt      <= '0;
            pkt_ok_out   <= 1'b0;
            pkt_err_out  <= 1'b0;
            err_code_out <= 3'd0;
        end else begin
            pkt_ok_out  <= 1'b0;
            pkt_err_out <= 1'b0;

            if (new_data_in) begin
                tmo_cnt <= '0;
            end else if (state != IDLE) begin
                tmo_cnt <= tmo_hit ? '0 : tmo_cnt + TMO_ONE;
            end

            case (state)
                IDLE: begin
                    if (new_data_in) begin
                        if (!hdr_ok) begin
                            pkt_err_out  <= 1'b1;
                            err_code_out <= ERR_BAD_HDR;
                        end else if (hdr_fits) begin
                            cnt    <= hdr_n;
                            wr_tmp <= wr_commit;
                            state  <= PAYLOAD;
                        end else begin
                            // No room: swallow the rest of the packet (payload + checksum).
                            pkt_err_out  <= 1'b1;
                            err_code_out <= ERR_OVERFLOW;
                            cnt          <= hdr_n + 9'd1;
                            state        <= DROP;
                        end
                    end
                end
                PAYLOAD: begin
                    if (new_data_in) begin
                        wr_tmp <= wr_tmp + PTR_ONE;
                        cnt    <= cnt - 9'd1;
                        if (cnt == 9'd1) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (new_data_in) begin
                        if (data_in == sum) begin
                            wr_commit  <= wr_tmp;
                            pkt_ok_out <= 1'b1;
                        end else begin
                            wr_tmp       <= wr_commit;
                            pkt_err_out  <= 1'b1;
                            err_code_out <= ERR_CHECKSUM;
                        end
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (new_data_in) begin
                        cnt <= cnt - 9'd1;
                        if (cnt == 9'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Stalled mid-packet: abandon it. A word arriving this cycle takes priority.
            if (!new_data_in && (state != IDLE) && tmo_hit) begin
                wr_tmp       <= wr_commit;
                pkt_err_out  <= 1'b1;
                err_code_out <= ERR_TIMEOUT;
                state        <= IDLE;
            end
        end
    end

`ifdef SPI_PKT_STATS_EN
    // Saturating totals of committed packets and reported errors.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pkt_count_out <= 16'd0;
            err_count_out <= 16'd0;
        end else begin
            if (pkt_ok_out) begin
                pkt_count_out <= sat_inc(pkt_count_out);
            end
            if (pkt_err_out) begin
                err_count_out <= sat_inc(err_count_out);
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_packet_rx.sv
// Testbench for spi_packet_rx: directed packets against a packet-level model
// (expected word queue, expected error-code queue) checked every cycle.
module tb_spi_packet_rx;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [15:0] data_in;
    logic        new_data_in;
    logic [15:0] word_out;
    logic        last_out;
    logic        valid_out;
    logic        ready_in;
    logic        pkt_ok_out;
    logic        pkt_err_out;
    logic [2:0]  err_code_out;
`ifdef SPI_PKT_STATS_EN
    logic [15:0] pkt_count_out;
    logic [15:0] err_count_out;
`endif

    spi_packet_rx dut (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .data_in      (data_in),
        .new_data_in  (new_data_in),
        .word_out     (word_out),
        .last_out     (last_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .pkt_ok_out   (pkt_ok_out),
        .pkt_err_out  (pkt_err_out),
        .err_code_out (err_code_out)
`ifdef SPI_PKT_STATS_EN
        ,
        .pkt_count_out(pkt_count_out),
        .err_count_out(err_count_out)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [16:0] exp_q[$];
    logic [2:0]  code_q[$];
    logic [16:0] pop_log[$];
    logic [2:0]  held_code = 3'd0;
    int          ok_seen = 0;
    int          err_seen = 0;
    int          exp_ok = 0;
    int          exp_err = 0;
    logic [15:0] pbuf [64];
    logic [15:0] last_sum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the packet-level model.
    always @(negedge clk) begin
        if (pkt_err_out) begin
            err_seen++;
            check("err_pulse_expected", (code_q.size() > 0), 1);
            if (code_q.size() > 0) begin
                held_code = code_q.pop_front();
                check("err_code", err_code_out, held_code);
            end
        end else begin
            check("err_code_hold", err_code_out, held_code);
        end
        if (pkt_ok_out) ok_seen++;
        if (valid_out) begin
            check("valid_only_when_committed", (exp_q.size() > 0), 1);
            if ((exp_q.size() > 0) && ready_in) begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("popped_word", {last_out, word_out}, e);
                pop_log.push_back({last_out, word_out});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        data_in = w;
        new_data_in = 1'b1;
        @(posedge clk);
        #1;
        new_data_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Sends header, payload from pbuf and checksum; records what must come out.
    task automatic send_pkt(input logic [15:0] hdr, input bit bad_chk);
        logic [15:0] s;
        logic [15:0] chk;
        int n;
        int nfree;
        n = int'(hdr[7:0]);
        if (hdr[15:8] != 8'hA5 || n < 1 || n > 16) begin
            code_q.push_back(3'd1);
            exp_err++;
            send_word(hdr);
            return;
        end
        s = hdr;
        for (int i = 0; i < n; i++) s = s + pbuf[i];
        last_sum = s;
        chk = bad_chk ? s + 16'd1 : s;
        nfree = 32 - exp_q.size();
        if (nfree < n) begin
            code_q.push_back(3'd2);
            exp_err++;
            send_word(hdr);
            for (int i = 0; i < n; i++) send_word(pbuf[i]);
            send_word(chk);
            return;
        end
        send_word(hdr);
        for (int i = 0; i < n; i++) send_word(pbuf[i]);
        if (bad_chk) begin
            code_q.push_back(3'd3);
            exp_err++;
        end else begin
            for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), pbuf[i]});
            exp_ok++;
        end
        send_word(chk);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_ok_pulses"}, ok_seen, exp_ok);
        check({tag, "_err_pulses"}, err_seen, exp_err);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, valid_out, 0);
        check({tag, "_ok"}, pkt_ok_out, 0);
        check({tag, "_err"}, pkt_err_out, 0);
        check({tag, "_code"}, err_code_out, 0);
        check({tag, "_word"}, word_out, 0);
        check({tag, "_last"}, last_out, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_in = 1'b1;
        new_data_in = 1'b0;
        data_in = 16'd0;
        ready_in = 1'b0;
        #2 rst_in = 1'b0;
        #1 check_idle_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_in = 1'b1;
        idle(2);

        // Good two-word packet, consumer always ready.
        ready_in = 1'b1;
        pop_log.delete();
        pbuf[0] = 16'h1234;
        pbuf[1] = 16'h0001;
        send_pkt(16'hA502, 1'b0);
        idle(3);
        check("t1_model_sum", last_sum, 16'hB737);
        check_counts("t1");
        check("t1_npop", pop_log.size(), 2);
        check("t1_word0", pop_log[0], {1'b0, 16'h1234});
        check("t1_word1", pop_log[1], {1'b1, 16'h0001});
        check("t1_code", err_code_out, 0);
        check("t1_empty", valid_out, 0);

        // Same packet with a wrong checksum, then a good one whose sum wraps.
        send_pkt(16'hA502, 1'b1);
        idle(3);
        check_counts("t2");
        check("t2_code", err_code_out, 3);
        check("t2_empty", valid_out, 0);
        pop_log.delete();
        pbuf[0] = 16'hFFFF;
        pbuf[1] = 16'h0002;
        send_pkt(16'hA502, 1'b0);
        idle(3);
        check("t2_model_sum", last_sum, 16'hA503);
        check_counts("t2b");
        check("t2b_word0", pop_log[0], {1'b0, 16'hFFFF});
        check("t2b_word1", pop_log[1], {1'b1, 16'h0002});

        // Bad headers: wrong sync, zero length, length above maximum.
        send_pkt(16'h5502, 1'b0);
        idle(2);
        check("t3_code_sync", err_code_out, 1);
        send_pkt(16'hA500, 1'b0);
        send_pkt(16'hA511, 1'b0);
        idle(2);
        check_counts("t3");
        check("t3_code", err_code_out, 1);

        // Fill the FIFO with two full packets, then overflow and drop.
        ready_in = 1'b0;
        for (int i = 0; i < 16; i++) pbuf[i] = 16'h0100 + 16'(i);
        send_pkt(16'hA510, 1'b0);
        for (int i = 0; i < 16; i++) pbuf[i] = 16'h0200 + 16'(i);
        send_pkt(16'hA510, 1'b0);
        idle(2);
        check("t4_full_valid", valid_out, 1);
        pbuf[0] = 16'hDEAD;
        send_pkt(16'hA501, 1'b0);
        idle(2);
        check_counts("t4");
        check("t4_code", err_code_out, 2);
        pop_log.delete();
        ready_in = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
        idle(2);
        check("t4_drained", exp_q.size(), 0);
        check("t4_npop", pop_log.size(), 32);
        check("t4_first", pop_log[0], {1'b0, 16'h0100});
        check("t4_last16", pop_log[15], {1'b1, 16'h010F});
        check("t4_entry17", pop_log[16], {1'b0, 16'h0200});
        check("t4_last32", pop_log[31], {1'b1, 16'h020F});
        check("t4_empty", valid_out, 0);
        pbuf[0] = 16'h0042;
        send_pkt(16'hA501, 1'b0);
        idle(3);
        check_counts("t4b");

        // Stall mid-packet until the inter-word timeout fires.
        base = err_seen;
        code_q.push_back(3'd4);
        exp_err++;
        send_word(16'hA503);
        send_word(16'h0001);
        idle(980);
        check("t5_no_early_timeout", err_seen, base);
        for (int i = 0; i < 60 && err_seen == base; i++) idle(1);
        idle(1);
        check_counts("t5");
        check("t5_code", err_code_out, 4);
        check("t5_empty", valid_out, 0);
        pbuf[0] = 16'h00AA;
        pbuf[1] = 16'h00BB;
        send_pkt(16'hA502, 1'b0);
        idle(3);
        check_counts("t5b");

        // Asynchronous reset in the middle of a payload.
        send_word(16'hA503);
        data_in = 16'h0007;
        new_data_in = 1'b1;
        @(posedge clk);
        #1 new_data_in = 1'b0;
        #1 rst_in = 1'b0;
        held_code = 3'd0;
        #1 check_idle_outputs("t6_reset");
        idle(2);
        rst_in = 1'b1;
        idle(2);
        pop_log.delete();
        pbuf[0] = 16'h1111;
        pbuf[1] = 16'h2222;
        pbuf[2] = 16'h3333;
        send_pkt(16'hA503, 1'b0);
        idle(4);
        check_counts("t6");
        check("t6_npop", pop_log.size(), 3);
        check("t6_word2", pop_log[2], {1'b1, 16'h3333});
        check("t6_model_sum", last_sum, 16'h0B69);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_packet_rx.md
Name: spi_packet_rx

Overview:
Consumes the word stream that spi_rx produces (data_out/new_data_out) and assembles it into checked packets. Each packet is a header word, then N payload words, then a checksum word. Payload words are held in a FIFO and released to the downstream consumer over valid/ready only after the checksum passes; failed packets are discarded by rewinding the FIFO. Sits between spi_rx and the application logic.

Parameters:
SYNC_BYTE, 8'hA5, required upper byte of header word
MAX_PAYLOAD, 16, largest legal N (1..255)
FIFO_DEPTH, 32, payload FIFO entries (power of 2, >= MAX_PAYLOAD)
TIMEOUT_CYCLES, 1000, max clk_in cycles between words inside a packet

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
data_in  input  16  word from spi_rx
new_data_in  input  1  1-cycle strobe, data_in valid
word_out  output  16  head-of-FIFO payload word
last_out  output  1  word_out is final word of its packet
valid_out  output  1  committed word available
ready_in  input  1  consumer accepts word_out when valid_out&&ready_in
pkt_ok_out  output  1  1-cycle pulse, packet committed
pkt_err_out  output  1  1-cycle pulse, packet/header rejected
err_code_out  output  3  cause of last error, held until next error

Behaviour:
- Reset (rst_in low, async): state IDLE, all pointers 0, valid_out=0, pkt_ok_out=0, pkt_err_out=0, err_code_out=0, timeout counter 0.
- Header: upper byte = SYNC_BYTE, lower byte = N. Checksum word = 16-bit sum mod 2^16 of header and all payload words.
- FIFO entries are 17 bits {last, word}. Pointers: rd_ptr, wr_commit, wr_tmp. Free space = FIFO_DEPTH - (wr_commit - rd_ptr).
- valid_out = (rd_ptr != wr_commit), derived from registers. word_out/last_out = mem[rd_ptr]. A pop advances rd_ptr on the same edge.
- States:
  IDLE: on strobe, a valid header has N in 1..MAX_PAYLOAD. If free >= N: sum<=header, cnt<=N, wr_tmp<=wr_commit, go PAYLOAD. If free < N: pulse err, code 2 (OVERFLOW), cnt<=N+1, go DROP. An invalid header pulses err with code 1 (BAD_HDR) and stays IDLE.
  PAYLOAD: on strobe: write mem[wr_tmp], with last=(cnt==1). Then wr_tmp++, sum+=data, cnt--. When cnt reaches 0, go CHECK.
  CHECK: on strobe: if data==sum, wr_commit<=wr_tmp and pulse pkt_ok_out. Otherwise wr_tmp<=wr_commit, pulse err with code 3 (CHECKSUM). Return to IDLE.
  DROP: count down cnt on each strobe. At 0, return to IDLE with no further pulse.
- Timeout: the counter clears on every strobe and increments in PAYLOAD/CHECK/DROP. When it reaches TIMEOUT_CYCLES: wr_tmp<=wr_commit, pulse err with code 4 (TIMEOUT), go IDLE. A strobe arriving on the same cycle as expiry wins: the word is processed and the counter clears.
- Pulses (pkt_ok_out, pkt_err_out) are registered and occur on the cycle after the deciding strobe. valid_out for a committed packet also rises on that same cycle.
- Pops during PAYLOAD/CHECK are always legal and only touch rd_ptr. Uncommitted words are never visible.
- Pointer arithmetic wraps mod FIFO_DEPTH, with one extra wrap bit so full and empty are distinguishable.

Optional Feature:
SPI_PKT_STATS_EN defined: adds outputs pkt_count_out[15:0] and err_count_out[15:0]. They increment on pkt_ok_out and pkt_err_out respectively, saturate at 16'hFFFF, and reset to 0.
Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Send 0xA502, 0x1234, 0x0001, 0xB737 with ready_in=1 -> pkt_ok_out pulses once; consumer sees 0x1234 (last=0) then 0x0001 (last=1); err_code_out stays 0.
- Same packet with checksum 0xB738 -> pkt_err_out pulses with err_code_out=3; valid_out never rises. A following good packet is delivered intact.
- Send 0x5502 -> pkt_err_out with code 1, state stays IDLE. 0xA500 and 0xA511 (MAX_PAYLOAD=16) -> code 1 each.
- ready_in=0, send two good 16-word packets (32 entries full), then header 0xA501 -> code 2; the next 2 words are dropped silently. Then raise ready_in -> 32 words drain in order, with last_out on entries 16 and 32.
- Send 0xA503, 0x0001, then idle 1000 cycles -> pkt_err_out with code 4; FIFO stays empty; a later good packet passes.
- Assert rst_in low mid-PAYLOAD -> all outputs 0 immediately; a packet sent after release is delivered correctly.
